joypad_poller: RTL

JOYPAD_POLLER -- requirements
Module: joypad_poller

---
 rtl/joypad_poller.sv | 133 +++++++++++++
 1 files changed

// File: rtl/joypad_poller.sv
// joypad_poller: polls two serial joypads (strobe, 8 clock pulses) and publishes button bytes.
// Optional JOYPAD_DEBOUNCE_EN: buttons update only when two consecutive polls agree.
module joypad_poller #(
  parameter int STROBE_CYCLES = 12,
  parameter int HALF_PERIOD = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ce,
  input  logic       start,
  output logic       joypad_strobe,
  output logic [1:0] joypad_clock,
  input  logic [1:0] joypad_data,
  output logic [7:0] buttons1,
  output logic [7:0] buttons2,
  output logic       valid,
  output logic       busy
);
  localparam int MAXC = STROBE_CYCLES > HALF_PERIOD ? STROBE_CYCLES : HALF_PERIOD;
  localparam int CW = $clog2(MAXC + 1);
  typedef enum logic [2:0] {IDLE, STROBE, LOW, HIGH, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] sh1_q, sh1_d, sh2_q, sh2_d, b1_q, b1_d, b2_q, b2_d;
  logic strobe_q, strobe_d, valid_q, valid_d, busy_q, busy_d;
  logic [1:0] clock_q, clock_d;
  logic half_last;
`ifdef JOYPAD_DEBOUNCE_EN
  logic [7:0] hist1_q, hist1_d, hist2_q, hist2_d;
`endif
  assign half_last = cnt_q == CW'(HALF_PERIOD - 1);
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    idx_d = idx_q;
    sh1_d = sh1_q;
    sh2_d = sh2_q;
    b1_d = b1_q;
    b2_d = b2_q;
    valid_d = 1'b0;
`ifdef JOYPAD_DEBOUNCE_EN
    hist1_d = hist1_q;
    hist2_d = hist2_q;
`endif
    if (ce) begin
      case (state_q)
        IDLE: if (start) begin
          state_d = STROBE;
          cnt_d = '0;
        end
        STROBE: if (cnt_q == CW'(STROBE_CYCLES - 1)) begin
          state_d = LOW;
          cnt_d = '0;
          idx_d = '0;
        end else cnt_d = cnt_q + CW'(1);
        LOW: if (half_last) begin
          sh1_d[idx_q] = joypad_data[0];
          sh2_d[idx_q] = joypad_data[1];
          state_d = HIGH;
          cnt_d = '0;
        end else cnt_d = cnt_q + CW'(1);
        HIGH: if (half_last) begin
          state_d = idx_q == 3'd7 ? DONE : LOW;
          idx_d = idx_q + 3'd1;
          cnt_d = '0;
        end else cnt_d = cnt_q + CW'(1);
        DONE: begin
`ifdef JOYPAD_DEBOUNCE_EN
          b1_d = sh1_q == hist1_q ? sh1_q : b1_q;
          b2_d = sh2_q == hist2_q ? sh2_q : b2_q;
          hist1_d = sh1_q;
          hist2_d = sh2_q;
`else
          b1_d = sh1_q;
          b2_d = sh2_q;
`endif
          valid_d = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    // Pin outputs are decoded from the next state so they are registered alongside it.
    strobe_d = state_d == STROBE;
    clock_d = {2{state_d == HIGH}};
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      sh1_q <= '0;
      sh2_q <= '0;
      b1_q <= '0;
      b2_q <= '0;
      strobe_q <= 1'b0;
      clock_q <= '0;
      valid_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      sh1_q <= sh1_d;
      sh2_q <= sh2_d;
      b1_q <= b1_d;
      b2_q <= b2_d;
      strobe_q <= strobe_d;
      clock_q <= clock_d;
      valid_q <= valid_d;
      busy_q <= busy_d;
    end
  end
`ifdef JOYPAD_DEBOUNCE_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      hist1_q <= '0;
      hist2_q <= '0;
    end else begin
      hist1_q <= hist1_d;
      hist2_q <= hist2_d;
    end
  end
`endif
  assign joypad_strobe = strobe_q;
  assign joypad_clock = clock_q;
  assign buttons1 = b1_q;
  assign buttons2 = b2_q;
  assign valid = valid_q;
  assign busy = busy_q;
endmodule
